// File: rtl/toggle_decoder.sv
// toggle_decoder: recovers T events from a toggle-coded level and queues them behind a valid/ready counter.
// Optional macro TOGGLE_DECODER_GLITCH_FILTER_EN: a level change must persist two edges to be accepted.
module toggle_decoder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_in,
  input  logic             clr,
  input  logic             evt_ready,
  output logic             t_out,
  output logic             evt_valid,
  output logic [CNT_W-1:0] evt_count,
  output logic             level,
  output logic             overflow
);

  localparam int unsigned        INIT_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [INIT_W-1:0]  INIT_LAST = INIT_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [INIT_W-1:0]      init_cnt_q, init_cnt_d;
  logic                   prev_q, prev_d;
  logic                   level_d;
  logic                   t_out_d;
  logic                   overflow_d;
  logic [CNT_W-1:0]       cnt_d;
  logic                   diff;
  logic                   toggle;
  logic                   inc;
  logic                   dec;

`ifdef TOGGLE_DECODER_GLITCH_FILTER_EN
  logic pend_q, pend_d;
`endif

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign evt_valid = (evt_count != '0);

  // Input synchronizer; cleared on reset so in-flight samples are discarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], q_in};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_cnt_q <= '0;
      prev_q     <= 1'b0;
      level      <= 1'b0;
      t_out      <= 1'b0;
      evt_count  <= '0;
      overflow   <= 1'b0;
    end else begin
      init_cnt_q <= init_cnt_d;
      prev_q     <= prev_d;
      level      <= level_d;
      t_out      <= t_out_d;
      evt_count  <= cnt_d;
      overflow   <= overflow_d;
    end
  end

`ifdef TOGGLE_DECODER_GLITCH_FILTER_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prev_d     = prev_q;
    level_d    = level;
    t_out_d    = 1'b0;
    cnt_d      = evt_count;
    overflow_d = overflow;
    diff       = (sync_out != prev_q);
    toggle     = 1'b0;
    inc        = 1'b0;
    dec        = evt_valid & evt_ready;
`ifdef TOGGLE_DECODER_GLITCH_FILTER_EN
    pend_d     = 1'b0;
`endif

    case (state_q)
      // Track the synchronized level without events until the chain holds real samples.
      INIT: begin
        prev_d     = sync_out;
        level_d    = sync_out;
        init_cnt_d = init_cnt_q + INIT_W'(1);
        if (init_cnt_q == INIT_LAST) begin
          state_d    = RUN;
          init_cnt_d = '0;
        end
      end
      RUN: begin
`ifdef TOGGLE_DECODER_GLITCH_FILTER_EN
        pend_d = diff & ~pend_q;
        toggle = diff & pend_q;
`else
        toggle = diff;
`endif
        if (toggle) begin
          prev_d  = sync_out;
          level_d = sync_out;
        end
        t_out_d = toggle;
        inc     = toggle;
      end
      default: begin
        state_d = INIT;
      end
    endcase

    // Pending-event counter: clear wins, then saturating inc/dec.
    if (clr) begin
      cnt_d      = '0;
      overflow_d = 1'b0;
    end else if (inc && !dec) begin
      if (evt_count == CNT_MAX) begin
        overflow_d = 1'b1;
      end else begin
        cnt_d = evt_count + CNT_W'(1);
      end
    end else if (dec && !inc) begin
      cnt_d = evt_count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_toggle_decoder.sv
// Self-checking bench for toggle_decoder: pulse times scoreboarded, counter states checked at fixed points.
module tb_toggle_decoder;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CNT_W       = 4;
`ifdef TOGGLE_DECODER_GLITCH_FILTER_EN
  localparam int LAT = SYNC_STAGES + 1;
`else
  localparam int LAT = SYNC_STAGES;
`endif

  logic             clk;
  logic             rst;
  logic             q_in;
  logic             clr;
  logic             evt_ready;
  logic             t_out;
  logic             evt_valid;
  logic [CNT_W-1:0] evt_count;
  logic             level;
  logic             overflow;

  int checks;
  int failures;
  int cyc;
  int exp_q[$];

  toggle_decoder #(
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .q_in     (q_in),
    .clr      (clr),
    .evt_ready(evt_ready),
    .t_out    (t_out),
    .evt_valid(evt_valid),
    .evt_count(evt_count),
    .level    (level),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Compare t_out against the expected pulse cycles queued by set_q.
  task automatic monitor();
    if (exp_q.size() != 0 && exp_q[0] == cyc) begin
      chk("t_out_pulse", 32'(t_out), 32'd1);
      void'(exp_q.pop_front());
    end else if (t_out) begin
      chk("t_out_spurious", 32'(t_out), 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive q_in after an edge; a change is seen at the next edge and pulses LAT edges later.
  task automatic set_q(input logic v);
    if (v !== q_in) exp_q.push_back(cyc + 1 + LAT);
    q_in = v;
  endtask

  task automatic check_state(input string tag, input int cnt, input logic ovf);
    chk({tag, "_count"}, 32'(evt_count), 32'(cnt));
    chk({tag, "_valid"}, 32'(evt_valid), 32'(cnt != 0));
    chk({tag, "_overflow"}, 32'(overflow), 32'(ovf));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    q_in      = 1'b1;
    clr       = 1'b0;
    evt_ready = 1'b0;
    rst       = 1'b1;
    #2 rst = 1'b0;

    // Reset with q_in high: no event on release, level settles to 1.
    ticks(2);
    chk("rst_t_out", 32'(t_out), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    check_state("rst", 0, 1'b0);
    rst = 1'b1;
    ticks(6);
    chk("init_level", 32'(level), 32'd1);
    check_state("init", 0, 1'b0);

    // Two toggles held 3 cycles each.
    set_q(1'b0); ticks(3);
    set_q(1'b1); ticks(3);
    ticks(LAT + 1);
    chk("two_level", 32'(level), 32'd1);
    check_state("two", 2, 1'b0);

    // Drain with ready; third accept ignored at count 0.
    evt_ready = 1'b1;
    tick(); check_state("drain1", 1, 1'b0);
    tick(); check_state("drain2", 0, 1'b0);
    tick(); check_state("drain3", 0, 1'b0);
    evt_ready = 1'b0;

    // Saturation and overflow, then clear.
    for (int i = 0; i < 15; i++) begin
      set_q(~q_in); ticks(2);
    end
    ticks(LAT + 1);
    check_state("sat15", 15, 1'b0);
    set_q(~q_in); ticks(LAT + 2);
    check_state("sat16", 15, 1'b1);
    clr = 1'b1; tick(); clr = 1'b0;
    check_state("clr", 0, 1'b0);

    // Toggle coinciding with an accept keeps the count.
    for (int i = 0; i < 3; i++) begin
      set_q(~q_in); ticks(2);
    end
    ticks(LAT + 1);
    check_state("cnt3", 3, 1'b0);
    set_q(~q_in); ticks(LAT);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    check_state("inc_dec", 3, 1'b0);
    tick();
    check_state("inc_dec_hold", 3, 1'b0);

    // Toggle on a clear cycle still pulses but is not counted.
    set_q(~q_in); ticks(LAT);
    clr = 1'b1; tick(); clr = 1'b0;
    check_state("clr_toggle", 0, 1'b0);
    chk("clr_toggle_level", 32'(level), 32'(q_in));

    // Asynchronous reset with count 5 and a toggle in the synchronizer.
    for (int i = 0; i < 5; i++) begin
      set_q(~q_in); ticks(2);
    end
    ticks(LAT + 1);
    check_state("cnt5", 5, 1'b0);
    set_q(~q_in); tick();
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_t_out", 32'(t_out), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    check_state("arst", 0, 1'b0);
    ticks(2);
    rst = 1'b1;
    ticks(SYNC_STAGES + 6);
    chk("post_rst_level", 32'(level), 32'(q_in));
    check_state("post_rst", 0, 1'b0);

`ifdef TOGGLE_DECODER_GLITCH_FILTER_EN
    // Single-cycle glitch is rejected.
    q_in = ~q_in; tick();
    q_in = ~q_in; ticks(6);
    chk("glitch_level", 32'(level), 32'(q_in));
    check_state("glitch", 0, 1'b0);
`endif

    ticks(LAT + 2);
    chk("pending_pulses", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
